cory_axi_copy: RTL and testbench



---
 rtl/cory_axi_copy_pkg.sv | 26 ++
 rtl/cory_axi_copy_fifo.sv | 50 +++++
 rtl/cory_axi_copy.sv | 221 ++++++++++++++++++++++
 tb/tb_cory_axi_copy.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cory_axi_copy_pkg.sv
// Shared types and helpers for the AXI copy engine.
//   rd_state_e / wr_state_e : read and write FSM encodings
//   f_log2                  : ceiling log2, usable in constant expressions
package cory_axi_copy_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_e;

  function automatic int f_log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cory_axi_copy_fifo.sv
// Read-data buffer between the read and write sides of the copy engine.
//   clk, reset        : clock, synchronous active-high reset (flushes)
//   push_i / din_i    : write one word
//   pop_i / dout_o    : dout_o is the head word; pop_i advances it
//   count_o           : words currently stored
// Push and pop in the same cycle are both honoured. DEPTH must be a power
// of two so the pointers wrap naturally.
module cory_axi_copy_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/cory_axi_copy.sv
// AXI-style burst copy master: reads i_size bytes from i_src in AR/R bursts
// into a local FIFO and writes them to i_dst in AW/W/B bursts.
//   clk, reset            : clock, synchronous active-high reset
//   i_start/i_src/i_dst/i_size : copy request, sampled only while idle
//   o_busy/o_done/o_err   : status; o_err is sticky until the next start
//   o_ar_*/i_ar_r, i_r_*/o_r_r   : read address / data channels
//   o_aw_*/i_aw_r, o_w_*/i_w_r, i_b_v/o_b_r : write channels
// One burst outstanding per direction; read and write sides run concurrently.
module cory_axi_copy
  import cory_axi_copy_pkg::*;
#(
  parameter int A          = 32,
  parameter int D          = 64,
  parameter int L          = 4,
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [A-1:0] i_src,
  input  logic [A-1:0] i_dst,
  input  logic [A-1:0] i_size,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic         o_ar_v,
  output logic [A-1:0] o_ar_a,
  output logic [L-1:0] o_ar_l,
  input  logic         i_ar_r,
  input  logic         i_r_v,
  input  logic [D-1:0] i_r_d,
  input  logic         i_r_l,
  output logic         o_r_r,
  output logic         o_aw_v,
  output logic [A-1:0] o_aw_a,
  output logic [L-1:0] o_aw_l,
  input  logic         i_aw_r,
  output logic         o_w_v,
  output logic [D-1:0] o_w_d,
  output logic         o_w_l,
  input  logic         i_w_r,
  input  logic         i_b_v,
  output logic         o_b_r
);
  localparam int NB = D / 8;
  localparam int LB = f_log2(NB);
  localparam int RW = A - LB;                     // remaining-word counters
  localparam int CW = f_log2(FIFO_DEPTH) + 1;
  localparam int BW = L + 1;                      // holds 0..BURST

  rd_state_e      rd_q, rd_d;
  wr_state_e      wr_q, wr_d;
  logic [A-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [RW-1:0]  rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
  logic [BW-1:0]  rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic           early_q, early_d;               // i_r_l seen before last beat
  logic [BW-1:0]  rbeats, wbeats;
  logic [CW-1:0]  fcnt;
  logic           push, pop, wlast;
  logic [RW-1:0]  words;

  // Burst lengths follow the remaining counters, which only move at burst
  // boundaries, so they stay stable for the whole burst.
  assign rbeats = (rd_rem_q >= RW'(BURST)) ? BW'(BURST) : BW'(rd_rem_q);
  assign wbeats = (wr_rem_q >= RW'(BURST)) ? BW'(BURST) : BW'(wr_rem_q);
  assign words  = RW'(i_size >> LB);
  assign wlast  = (wcnt_q == wbeats - 1'b1);

  cory_axi_copy_fifo #(.W(D), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (i_r_d),
    .pop_i   (pop),
    .dout_o  (o_w_d),
    .count_o (fcnt)
  );

  always_comb begin
    rd_d      = rd_q;
    wr_d      = wr_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    rd_rem_d  = rd_rem_q;
    wr_rem_d  = wr_rem_q;
    rcnt_d    = rcnt_q;
    wcnt_d    = wcnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    early_d   = early_q;
    push      = 1'b0;
    pop       = 1'b0;
    o_ar_v    = 1'b0;
    o_r_r     = 1'b0;
    o_aw_v    = 1'b0;
    o_w_v     = 1'b0;
    o_w_l     = 1'b0;
    o_b_r     = 1'b0;

    if (!busy_q && i_start) begin
      rd_addr_d = i_src & ~A'(NB - 1);
      wr_addr_d = i_dst & ~A'(NB - 1);
      rd_rem_d  = words;
      wr_rem_d  = words;
      err_d     = 1'b0;
      if (words != '0) busy_d = 1'b1;
      else             done_d = 1'b1;
    end

    case (rd_q)
      RD_IDLE: begin
        // Only ask for a burst the FIFO can fully absorb.
        if (busy_q && rd_rem_q != '0 &&
            (32'(FIFO_DEPTH) - 32'(fcnt)) >= 32'(rbeats))
          rd_d = RD_ADDR;
      end
      RD_ADDR: begin
        o_ar_v = 1'b1;
        if (i_ar_r) begin
          rd_d    = RD_DATA;
          rcnt_d  = '0;
          early_d = 1'b0;
        end
      end
      RD_DATA: begin
        o_r_r = 1'b1;
        if (i_r_v) begin
          push   = 1'b1;
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q + 1'b1 == rbeats) begin
            if (!i_r_l || early_q) err_d = 1'b1;
            rd_addr_d = rd_addr_q + (A'(rbeats) << LB);
            rd_rem_d  = rd_rem_q - RW'(rbeats);
            rd_d      = RD_IDLE;
          end else if (i_r_l) begin
            early_d = 1'b1;
          end
        end
      end
      default: rd_d = RD_IDLE;
    endcase

    case (wr_q)
      WR_IDLE: begin
        if (busy_q && wr_rem_q != '0 && 32'(fcnt) >= 32'(wbeats))
          wr_d = WR_ADDR;
      end
      WR_ADDR: begin
        o_aw_v = 1'b1;
        if (i_aw_r) begin
          wr_d   = WR_DATA;
          wcnt_d = '0;
        end
      end
      WR_DATA: begin
        o_w_v = 1'b1;
        o_w_l = wlast;
        if (i_w_r) begin
          pop    = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wlast) wr_d = WR_RESP;
        end
      end
      WR_RESP: begin
        o_b_r = 1'b1;
        if (i_b_v) begin
          wr_addr_d = wr_addr_q + (A'(wbeats) << LB);
          wr_rem_d  = wr_rem_q - RW'(wbeats);
          wr_d      = WR_IDLE;
          if (wr_rem_q == RW'(wbeats)) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      default: wr_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q      <= RD_IDLE;
      wr_q      <= WR_IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_rem_q  <= '0;
      wr_rem_q  <= '0;
      rcnt_q    <= '0;
      wcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_rem_q  <= rd_rem_d;
      wr_rem_q  <= wr_rem_d;
      rcnt_q    <= rcnt_d;
      wcnt_q    <= wcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      early_q   <= early_d;
    end
  end

  assign o_ar_a = rd_addr_q;
  assign o_ar_l = L'(rbeats - 1'b1);
  assign o_aw_a = wr_addr_q;
  assign o_aw_l = L'(wbeats - 1'b1);
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_cory_axi_copy.sv
// Bench for cory_axi_copy: an in-bench AXI memory responder, a table of
// directed copies, hand-written corner sequences and randomized copies.
module tb_cory_axi_copy;
  localparam int A = 32, D = 64, L = 4, MW = 1024;

  logic         clk = 1'b0, reset = 1'b1, i_start = 1'b0;
  logic [A-1:0] i_src = '0, i_dst = '0, i_size = '0;
  logic         o_busy, o_done, o_err;
  logic         o_ar_v;  logic [A-1:0] o_ar_a;  logic [L-1:0] o_ar_l;  logic i_ar_r = 1'b0;
  logic         i_r_v = 1'b0; logic [D-1:0] i_r_d = '0; logic i_r_l = 1'b0; logic o_r_r;
  logic         o_aw_v;  logic [A-1:0] o_aw_a;  logic [L-1:0] o_aw_l;  logic i_aw_r = 1'b0;
  logic         o_w_v;   logic [D-1:0] o_w_d;   logic o_w_l;   logic i_w_r = 1'b0;
  logic         i_b_v = 1'b0; logic o_b_r;

  always #5 clk = ~clk;

  cory_axi_copy #(.A(A), .D(D), .L(L), .BURST(16), .FIFO_DEPTH(32)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_src(i_src), .i_dst(i_dst),
    .i_size(i_size), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_ar_v(o_ar_v), .o_ar_a(o_ar_a), .o_ar_l(o_ar_l), .i_ar_r(i_ar_r),
    .i_r_v(i_r_v), .i_r_d(i_r_d), .i_r_l(i_r_l), .o_r_r(o_r_r),
    .o_aw_v(o_aw_v), .o_aw_a(o_aw_a), .o_aw_l(o_aw_l), .i_aw_r(i_aw_r),
    .o_w_v(o_w_v), .o_w_d(o_w_d), .o_w_l(o_w_l), .i_w_r(i_w_r),
    .i_b_v(i_b_v), .o_b_r(o_b_r)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [63:0] mem [MW];
  logic [63:0] orig [MW];
  logic [31:0] ar_la[$], aw_la[$];
  int          ar_ll[$], aw_ll[$];
  // responder state
  bit rd_act = 0, wr_act = 0, b_pend = 0;
  logic [31:0] rd_a = '0, wr_a = '0;
  int rd_len = 0, rd_beat = 0, wr_len = 0, wr_beat = 0, b_wait = 0;
  int p_rdy = 100, p_wr = 100, aw_stall = 0, inj_beat = -1;
  // observation
  int done_cnt = 0, done_cyc = 0, last_b_cyc = 0, start_cyc = 0;
  int stab_viol = 0, wl_viol = 0, w_total = 0;
  bit busy_at_done = 0;
  bit ar_hold = 0, aw_hold = 0, w_hold = 0;
  logic [31:0] h_ar_a, h_aw_a; logic [L-1:0] h_ar_l, h_aw_l;
  logic [63:0] h_w_d; logic h_w_l;

  typedef struct {
    int unsigned src, dst, size;
    int nb;        // expected number of bursts
    int last_len;  // expected len field of the final burst
  } vec_t;

  function automatic bit rnd(int p);
    return $urandom_range(99) < p;
  endfunction

  function automatic int idx(logic [31:0] a, int beat);
    return int'(((a >> 3) + 32'(beat)) & 32'd1023);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes at the negedge, let the edge happen, then
  // drive new responder inputs 1 time unit later.
  task automatic step();
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    @(negedge clk);
    if (o_done === 1'b1) begin done_cnt++; done_cyc = cyc; busy_at_done = o_busy; end
    if (ar_hold && !(o_ar_v === 1'b1 && o_ar_a === h_ar_a && o_ar_l === h_ar_l)) stab_viol++;
    if (aw_hold && !(o_aw_v === 1'b1 && o_aw_a === h_aw_a && o_aw_l === h_aw_l)) stab_viol++;
    if (w_hold  && !(o_w_v === 1'b1 && o_w_d === h_w_d && o_w_l === h_w_l)) stab_viol++;
    ar_hold = o_ar_v && !i_ar_r; h_ar_a = o_ar_a; h_ar_l = o_ar_l;
    aw_hold = o_aw_v && !i_aw_r; h_aw_a = o_aw_a; h_aw_l = o_aw_l;
    w_hold  = o_w_v && !i_w_r;   h_w_d  = o_w_d;  h_w_l  = o_w_l;
    ar_hs = o_ar_v && i_ar_r;  r_hs = i_r_v && o_r_r;
    aw_hs = o_aw_v && i_aw_r;  w_hs = o_w_v && i_w_r;  b_hs = i_b_v && o_b_r;
    if (reset) begin
      rd_act = 0; wr_act = 0; b_pend = 0; ar_hold = 0; aw_hold = 0; w_hold = 0;
    end else begin
      if (ar_hs) begin
        ar_la.push_back(o_ar_a); ar_ll.push_back(int'(o_ar_l));
        rd_act = 1; rd_a = o_ar_a; rd_len = int'(o_ar_l) + 1; rd_beat = 0;
      end
      if (r_hs) begin
        rd_beat++;
        if (rd_beat == rd_len) rd_act = 0;
      end
      if (aw_hs) begin
        aw_la.push_back(o_aw_a); aw_ll.push_back(int'(o_aw_l));
        wr_act = 1; wr_a = o_aw_a; wr_len = int'(o_aw_l) + 1; wr_beat = 0;
      end
      if (w_hs) begin
        if (o_w_l !== (wr_beat == wr_len - 1)) wl_viol++;
        mem[idx(wr_a, wr_beat)] = o_w_d;
        wr_beat++; w_total++;
        if (wr_beat == wr_len) begin wr_act = 0; b_pend = 1; b_wait = $urandom_range(3); end
      end
      if (b_hs) begin b_pend = 0; last_b_cyc = cyc; end
      else if (b_pend && b_wait > 0) b_wait--;
    end
    @(posedge clk);
    cyc++;
    #1;
    i_ar_r = !rd_act && rnd(p_rdy);
    i_r_v  = rd_act && rnd(p_rdy);
    i_r_d  = mem[idx(rd_a, rd_beat)];
    i_r_l  = rd_act && (rd_beat == rd_len - 1 || rd_beat == inj_beat);
    if (o_aw_v && aw_stall > 0) begin i_aw_r = 1'b0; aw_stall--; end
    else i_aw_r = !wr_act && !b_pend && rnd(p_rdy);
    i_w_r  = wr_act && rnd(p_wr);
    i_b_v  = b_pend && b_wait == 0;
  endtask

  task automatic kick(int unsigned src, int unsigned dst, int unsigned size);
    i_src = src; i_dst = dst; i_size = size; i_start = 1'b1;
    start_cyc = cyc;
    step();
    i_start = 1'b0;
  endtask

  task automatic run_copy(string nm, int unsigned src, int unsigned dst,
                          int unsigned size, bit mid, bit exp_err);
    logic [31:0] ea[$], ewa[$];
    int el[$];
    logic [31:0] ra, wa;
    int rem, n, words, bad, exp_done;
    for (int i = 0; i < MW; i++) begin
      mem[i] = {$urandom, $urandom};
      orig[i] = mem[i];
    end
    ar_la.delete(); ar_ll.delete(); aw_la.delete(); aw_ll.delete();
    done_cnt = 0; stab_viol = 0; wl_viol = 0; w_total = 0;
    // reference: split the word count into bursts of at most 16 beats
    words = int'(size / 8);
    ra = src & ~32'd7; wa = dst & ~32'd7; rem = words;
    while (rem > 0) begin
      n = (rem > 16) ? 16 : rem;
      ea.push_back(ra); ewa.push_back(wa); el.push_back(n - 1);
      ra += 32'(n * 8); wa += 32'(n * 8); rem -= n;
    end
    kick(src, dst, size);
    chk({nm, "_busy_start"}, 64'(o_busy), 64'(words != 0));
    chk({nm, "_err_clr"}, 64'(o_err), 64'd0);
    n = 0;
    while (done_cnt == 0 && n < 6000) begin
      if (mid && n == 10) begin
        i_src = 32'd512; i_dst = 32'd6000; i_size = 32'd64; i_start = 1'b1;
      end
      step();
      i_start = 1'b0;
      n++;
    end
    chk({nm, "_timeout"}, 64'(done_cnt != 0), 64'd1);
    exp_done = (words == 0) ? start_cyc + 1 : last_b_cyc + 1;
    chk({nm, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
    chk({nm, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    step(); step();
    chk({nm, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({nm, "_ar_cnt"}, 64'(ar_la.size()), 64'(ea.size()));
    chk({nm, "_aw_cnt"}, 64'(aw_la.size()), 64'(ea.size()));
    for (int k = 0; k < ea.size() && k < ar_la.size(); k++) begin
      chk({nm, "_ar_a"}, 64'(ar_la[k]), 64'(ea[k]));
      chk({nm, "_ar_l"}, 64'(ar_ll[k]), 64'(el[k]));
    end
    for (int k = 0; k < ea.size() && k < aw_la.size(); k++) begin
      chk({nm, "_aw_a"}, 64'(aw_la[k]), 64'(ewa[k]));
      chk({nm, "_aw_l"}, 64'(aw_ll[k]), 64'(el[k]));
    end
    bad = 0;
    for (int i = 0; i < words; i++)
      if (mem[idx(dst & ~32'd7, i)] !== orig[idx(src & ~32'd7, i)]) bad++;
    chk({nm, "_data_bad_words"}, 64'(bad), 64'd0);
    chk({nm, "_w_beats"}, 64'(w_total), 64'(words));
    chk({nm, "_err"}, 64'(o_err), 64'(exp_err));
    chk({nm, "_stable_viol"}, 64'(stab_viol), 64'd0);
    chk({nm, "_wlast_viol"}, 64'(wl_viol), 64'd0);
  endtask

  initial begin
    vec_t tbl[6];
    int n, d0;
    tbl[0] = '{src: 0,  dst: 4096, size: 128,  nb: 1, last_len: 15};
    tbl[1] = '{src: 0,  dst: 4096, size: 200,  nb: 2, last_len: 8};
    tbl[2] = '{src: 0,  dst: 4096, size: 0,    nb: 0, last_len: 0};
    tbl[3] = '{src: 64, dst: 2048, size: 1024, nb: 8, last_len: 15};
    tbl[4] = '{src: 13, dst: 3004, size: 48,   nb: 1, last_len: 5};
    tbl[5] = '{src: 8,  dst: 5000, size: 136,  nb: 2, last_len: 0};

    reset = 1'b1;
    repeat (3) step();
    chk("reset_state", 64'({o_ar_v, o_aw_v, o_w_v, o_r_r, o_b_r, o_busy, o_done, o_err}), 64'd0);
    reset = 1'b0;
    step();

    p_rdy = 70; p_wr = 70;
    foreach (tbl[i]) begin
      run_copy($sformatf("tbl%0d", i), tbl[i].src, tbl[i].dst, tbl[i].size, 0, 0);
      chk($sformatf("tbl%0d_nb", i), 64'(aw_la.size()), 64'(tbl[i].nb));
      if (tbl[i].nb > 0 && ar_ll.size() > 0)
        chk($sformatf("tbl%0d_last_len", i), 64'(ar_ll[ar_ll.size() - 1]), 64'(tbl[i].last_len));
    end

    // AW held off for 10 cycles, W ready toggling randomly
    p_rdy = 100; p_wr = 50; aw_stall = 10;
    run_copy("stall", 0, 4096, 256, 0, 0);

    // reset while W beat 5 is presented
    p_rdy = 80; p_wr = 80;
    done_cnt = 0; w_total = 0;
    kick(0, 4096, 256);
    n = 0;
    while (!(w_total == 4 && o_w_v === 1'b1) && n < 2000) begin step(); n++; end
    chk("rst_reach_beat5", 64'(n < 2000), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_outputs", 64'({o_ar_v, o_aw_v, o_w_v, o_r_r, o_b_r, o_busy, o_done}), 64'd0);
    d0 = done_cnt;
    repeat (5) step();
    chk("rst_no_done", 64'(done_cnt), 64'(d0));
    run_copy("post_rst", 0, 4096, 256, 0, 0);

    // early i_r_l on beat 3, plus a start while busy that must be ignored
    inj_beat = 2;
    run_copy("err", 0, 4096, 128, 1, 1);
    inj_beat = -1;
    run_copy("err_then", 0, 4096, 128, 0, 0);

    for (int r = 0; r < 6; r++) begin
      p_rdy = $urandom_range(40, 100);
      p_wr  = $urandom_range(40, 100);
      run_copy($sformatf("rnd%0d", r), $urandom_range(0, 2047),
               4096 + $urandom_range(0, 1535), $urandom_range(1, 64) * 8, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
